rij_ctrl_fsm: RTL and testbench
===============================

RIJ_CTRL_FSM -- requirements
Module: rij_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk  in  1  rising-edge clock`, `rst  in  1  synchronous active-high reset`.
REQ-002 `op  in  6  IR[31:26]`, stable from the end of IF onward.
REQ-003 `funct  in  6  IR[5:0]`.
REQ-004 `zf  in  1  ALU zero flag`; `of  in  1  ALU overflow flag`.
REQ-005 `alu_op  out  3  ALU operation`:
- 000 and, 001 or, 010 xor, 011 xnor
- 100 add, 101 sub, 110 unsigned less-than, 111 B<<A
REQ-006 `pc_write  out  1  PC load`; `pc_src  out  2  PC source` (00 PC+4, 01 branch target, 10 jump target).
REQ-007 `ir_write  out  1  IR load`.
REQ-008 `reg_write  out  1  register-file write`; `w_r_s  out  2  write-register select` (00 rd, 01 rt).
REQ-009 `wr_data_s  out  2  write-data select` (00 ALU F, 01 memory).
REQ-010 `rt_imm_s  out  1  ALU B operand` (0 rt, 1 immediate); `imm_s  out  1  immediate extension` (0 zero, 1 sign).
REQ-011 `mem_write  out  1  data-memory write`.
REQ-012 `illegal  out  1  one-cycle pulse on an undecodable instruction`.
REQ-013 `state  out  4  current state, for debug`.

Function
REQ-014 States SHALL be IF, ID, EX_R, EX_I, EX_MA, MEM_RD, MEM_WR, WB, BR, JMP.
REQ-015 IF SHALL assert ir_write=1, pc_write=1 and pc_src=00, then go to ID.
REQ-016 ID SHALL decode op and funct:
- op=000000 with a legal funct → EX_R
- addi, andi, ori, xori, sltiu → EX_I
- lw, sw → EX_MA
- beq, bne → BR
- j → JMP
- anything else → IF with illegal=1 for that cycle
REQ-017 R-type funct mapping SHALL be: 100100→000, 100101→001, 100110→010, 100111→011, 100000→100, 100010→101, 101011→110, 000100→111.
REQ-018 I-type opcode mapping SHALL be:
- addi 001000 → 100, sign-extend
- andi 001100 → 000, zero-extend
- ori 001101 → 001, zero-extend
- xori 001110 → 010, zero-extend
- sltiu 001011 → 110, sign-extend
REQ-019 alu_op SHALL be registered at the end of ID and held constant until the next ID.
REQ-020 EX_R and EX_I SHALL go to WB.
REQ-021 EX_MA SHALL drive alu_op=100 with rt_imm_s=1 and imm_s=1, then go to MEM_RD for lw or MEM_WR for sw.
REQ-022 MEM_RD SHALL go to WB with wr_data_s=01 and w_r_s=01.
REQ-023 MEM_WR SHALL assert mem_write=1 for exactly one cycle, then go to IF.
REQ-024 WB SHALL assert reg_write=1 for one cycle, then go to IF.
REQ-025 Overflow rule: when the instruction is add, sub or addi and `of` was 1 at the end of EX, WB SHALL keep reg_write=0.
- `of` SHALL be latched at the end of EX_R/EX_I.
REQ-026 BR SHALL drive alu_op=101 and rt_imm_s=0, then go to IF.
- beq: pc_write = zf.
- bne: pc_write = ~zf.
- pc_src=01 in both cases.
REQ-027 JMP SHALL assert pc_write=1 with pc_src=10, then go to IF.
REQ-028 Latency in cycles SHALL be: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3.
REQ-029 All strobe outputs (pc_write, ir_write, reg_write, mem_write, illegal) SHALL be 0 in every state not listed above.
REQ-030 The FSM SHALL NOT stall; there are no wait states.

Reset
REQ-031 When rst=1 at a clock edge, the next state SHALL be IF, overriding any in-progress state, including mid-EX_MA, MEM_WR and WB.
REQ-032 While rst=1, all strobes SHALL be 0, with alu_op=000, pc_src=00, and state=IF encoding (0000).
REQ-033 The first fetch SHALL occur on the first edge after rst falls.
REQ-034 The latched `of` SHALL clear to 0 on reset.

Structure
REQ-035 Shared package rij_pkg SHALL hold the state encodings, opcode and funct constants, and the ALU_OP constants.
REQ-036 A combinational sub-module, rij_alu_op_dec, SHALL implement the op/funct → {alu_op, imm_s, rt_imm_s, legal} mapping.
REQ-037 rij_ctrl_fsm SHALL hold the state register, the alu_op register and the latched `of`.

Verification
REQ-038 Reset: hold rst=1 for 3 cycles, then release. Required: state=IF and all strobes 0 during reset; ir_write=1 on the first cycle after release.
REQ-039 add with op=000000, funct=100000, of=0. Required: state sequence IF,ID,EX_R,WB; alu_op=100; reg_write=1 in WB only.
REQ-040 add with of=1 in EX_R. Required: reg_write stays 0 in WB. Then andi (001100). Required: alu_op=000, imm_s=0, reg_write=1.
REQ-041 lw (100011). Required: 5-cycle sequence ending in MEM_RD→WB with wr_data_s=01 and w_r_s=01.
- sw (101011). Required: mem_write=1 for exactly one cycle.
REQ-042 beq (000100):
- zf=1 → pc_write=1, pc_src=01 in BR.
- zf=0 → pc_write=0.
- bne (000101) with zf=0 → pc_write=1.
REQ-043 Illegal and interrupted cases:
- op=111111 → illegal pulses 1 cycle in ID, then IF.
- j (000010) → pc_src=10.
- rst asserted during MEM_WR → no further mem_write, and state=IF next cycle.

Source files
------------

// File: rtl/rij_pkg.sv
// Shared encodings for the RIJ multicycle controller: FSM states, opcodes, functs, ALU ops and mux selects.
// Also holds the helper that identifies instructions whose writeback is suppressed on overflow.
package rij_pkg;

   typedef enum logic [3:0] {
      ST_IF     = 4'd0,
      ST_ID     = 4'd1,
      ST_EX_R   = 4'd2,
      ST_EX_I   = 4'd3,
      ST_EX_MA  = 4'd4,
      ST_MEM_RD = 4'd5,
      ST_MEM_WR = 4'd6,
      ST_WB     = 4'd7,
      ST_BR     = 4'd8,
      ST_JMP    = 4'd9
   } rij_state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_XNOR = 6'b100111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_SLL  = 6'b000100;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_XNOR = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b111;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam logic [1:0] WRS_RD  = 2'b00;
   localparam logic [1:0] WRS_RT  = 2'b01;
   localparam logic [1:0] WDS_ALU = 2'b00;
   localparam logic [1:0] WDS_MEM = 2'b01;

   function automatic logic is_ovf_checked(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_ADDI) ||
             ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));
   endfunction

endpackage

// File: rtl/rij_alu_op_dec.sv
// Combinational op/funct decode into ALU operation, immediate handling and legality.
// Zero latency; pure function of the instruction fields.
module rij_alu_op_dec
   import rij_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_op,
   output logic       o_imm_s,
   output logic       o_rt_imm_s,
   output logic       o_legal
);

   always_comb begin
      o_alu_op   = ALU_AND;
      o_imm_s    = 1'b0;
      o_rt_imm_s = 1'b0;
      o_legal    = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            o_legal = 1'b1;
            case (i_funct)
               FN_AND:  o_alu_op = ALU_AND;
               FN_OR:   o_alu_op = ALU_OR;
               FN_XOR:  o_alu_op = ALU_XOR;
               FN_XNOR: o_alu_op = ALU_XNOR;
               FN_ADD:  o_alu_op = ALU_ADD;
               FN_SUB:  o_alu_op = ALU_SUB;
               FN_SLTU: o_alu_op = ALU_SLTU;
               FN_SLL:  o_alu_op = ALU_SLL;
               default: o_legal  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            o_alu_op = ALU_ADD;  o_imm_s = 1'b1; o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         OP_ANDI: begin
            o_alu_op = ALU_AND;  o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         OP_ORI: begin
            o_alu_op = ALU_OR;   o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         OP_XORI: begin
            o_alu_op = ALU_XOR;  o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         OP_SLTIU: begin
            o_alu_op = ALU_SLTU; o_imm_s = 1'b1; o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         // Loads/stores compute base + sign-extended offset.
         OP_LW, OP_SW: begin
            o_alu_op = ALU_ADD;  o_imm_s = 1'b1; o_rt_imm_s = 1'b1; o_legal = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            o_alu_op = ALU_SUB;  o_legal = 1'b1;
         end
         OP_J: o_legal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/rij_ctrl_fsm.sv
// Multicycle RIJ control FSM: IF/ID then per-class execute, memory and writeback states.
// Latency 2-5 cycles per instruction, never stalls; reset overrides all outputs combinationally.
module rij_ctrl_fsm
   import rij_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zf,
   input  logic       of,
   output logic [2:0] alu_op,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] w_r_s,
   output logic [1:0] wr_data_s,
   output logic       rt_imm_s,
   output logic       imm_s,
   output logic       mem_write,
   output logic       illegal,
   output logic [3:0] state
);

   rij_state_e r_state;
   rij_state_e w_next_state;
   logic [2:0] r_alu_op;
   logic       r_of;

   logic [2:0] w_dec_alu_op;
   logic       w_dec_imm_s;
   logic       w_dec_rt_imm_s;
   logic       w_dec_legal;

   rij_alu_op_dec u_dec (
      .i_op       (op),
      .i_funct    (funct),
      .o_alu_op   (w_dec_alu_op),
      .o_imm_s    (w_dec_imm_s),
      .o_rt_imm_s (w_dec_rt_imm_s),
      .o_legal    (w_dec_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IF;
         r_alu_op <= ALU_AND;
         r_of     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_ID)
            r_alu_op <= w_dec_alu_op;
         if ((r_state == ST_EX_R) || (r_state == ST_EX_I))
            r_of <= of;
      end
   end

   always_comb begin
      w_next_state = ST_IF;
      case (r_state)
         ST_IF: w_next_state = ST_ID;
         ST_ID: begin
            if (w_dec_legal) begin
               case (op)
                  OP_RTYPE:                                  w_next_state = ST_EX_R;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: w_next_state = ST_EX_I;
                  OP_LW, OP_SW:                              w_next_state = ST_EX_MA;
                  OP_BEQ, OP_BNE:                            w_next_state = ST_BR;
                  OP_J:                                      w_next_state = ST_JMP;
                  default:                                   w_next_state = ST_IF;
               endcase
            end
         end
         ST_EX_R, ST_EX_I: w_next_state = ST_WB;
         ST_EX_MA:  w_next_state = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD: w_next_state = ST_WB;
         default:   w_next_state = ST_IF;
      endcase
   end

   always_comb begin
      alu_op    = r_alu_op;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_SEQ;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      w_r_s     = WRS_RD;
      wr_data_s = WDS_ALU;
      rt_imm_s  = 1'b0;
      imm_s     = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
      state     = r_state;
      // The IR is only trustworthy after IF, so data selects follow it from ID on.
      if (r_state != ST_IF) begin
         w_r_s     = (op == OP_RTYPE) ? WRS_RD : WRS_RT;
         wr_data_s = (op == OP_LW) ? WDS_MEM : WDS_ALU;
         imm_s     = w_dec_imm_s;
      end
      case (r_state)
         ST_IF: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
         end
         ST_ID:             illegal   = ~w_dec_legal;
         ST_EX_I, ST_EX_MA: rt_imm_s  = w_dec_rt_imm_s;
         ST_MEM_WR:         mem_write = 1'b1;
         ST_WB:             reg_write = ~(r_of & is_ovf_checked(op, funct));
         ST_BR: begin
            pc_src   = PC_SRC_BR;
            pc_write = (op == OP_BNE) ? ~zf : zf;
         end
         ST_JMP: begin
            pc_src   = PC_SRC_JMP;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         alu_op    = ALU_AND;
         pc_write  = 1'b0;
         pc_src    = PC_SRC_SEQ;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         w_r_s     = WRS_RD;
         wr_data_s = WDS_ALU;
         rt_imm_s  = 1'b0;
         imm_s     = 1'b0;
         mem_write = 1'b0;
         illegal   = 1'b0;
         state     = ST_IF;
      end
   end

endmodule

// File: tb/tb_rij_ctrl_fsm.sv
// Bench for rij_ctrl_fsm: directed instruction table, reset interruptions and random instruction stream.
module tb_rij_ctrl_fsm;
   import rij_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zf = 1'b0;
   logic       of = 1'b0;
   logic [2:0] alu_op;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] w_r_s;
   logic [1:0] wr_data_s;
   logic       rt_imm_s;
   logic       imm_s;
   logic       mem_write;
   logic       illegal;
   logic [3:0] state;

   rij_ctrl_fsm dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zf(zf), .of(of),
      .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .reg_write(reg_write), .w_r_s(w_r_s), .wr_data_s(wr_data_s), .rt_imm_s(rt_imm_s),
      .imm_s(imm_s), .mem_write(mem_write), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] strobes();
      return {pc_write, ir_write, reg_write, mem_write, illegal};
   endfunction

   // Expected behaviour of one cycle of an instruction; c* flags mark fields that matter there.
   typedef struct {
      logic [3:0] st;
      logic [4:0] strb;
      bit         ca;  logic [2:0] alu;
      bit         cp;  logic [1:0] pcs;
      bit         cr;  logic       rt;
      bit         ci;  logic       imm;
      bit         cw;  logic [1:0] wrs; logic [1:0] wds;
   } exp_t;

   exp_t ex[8];
   int   ex_n;
   logic zf_a[8];
   logic of_a[8];

   function automatic exp_t step(input logic [3:0] st);
      exp_t e;
      e.st = st; e.strb = 5'b0;
      e.ca = 0; e.alu = 3'd0; e.cp = 0; e.pcs = 2'd0; e.cr = 0; e.rt = 1'b0;
      e.ci = 0; e.imm = 1'b0; e.cw = 0; e.wrs = 2'd0; e.wds = 2'd0;
      return e;
   endfunction

   // Reference: instruction class -> per-cycle trace, with zf/of taken from the drawn per-cycle values.
   task automatic build(input logic [5:0] bop, input logic [5:0] bfn);
      int cls; logic [2:0] alu; logic imm; logic ovf;
      cls = 0; alu = 3'd0; imm = 1'b0;
      case (bop)
         6'b000000: begin
            cls = 1;
            case (bfn)
               6'b100100: alu = 3'd0;  6'b100101: alu = 3'd1;
               6'b100110: alu = 3'd2;  6'b100111: alu = 3'd3;
               6'b100000: alu = 3'd4;  6'b100010: alu = 3'd5;
               6'b101011: alu = 3'd6;  6'b000100: alu = 3'd7;
               default:   cls = 0;
            endcase
         end
         6'b001000: begin cls = 2; alu = 3'd4; imm = 1'b1; end
         6'b001100: begin cls = 2; alu = 3'd0; end
         6'b001101: begin cls = 2; alu = 3'd1; end
         6'b001110: begin cls = 2; alu = 3'd2; end
         6'b001011: begin cls = 2; alu = 3'd6; imm = 1'b1; end
         6'b100011: cls = 3;
         6'b101011: cls = 4;
         6'b000100: cls = 5;
         6'b000101: cls = 6;
         6'b000010: cls = 7;
         default:   cls = 0;
      endcase
      ovf = (bop == 6'b001000) || (bop == 6'b000000 && (bfn == 6'b100000 || bfn == 6'b100010));
      ex[0] = step(ST_IF); ex[0].strb = 5'b11000; ex[0].cp = 1; ex[0].pcs = 2'b00;
      ex[1] = step(ST_ID); ex[1].strb = (cls == 0) ? 5'b00001 : 5'b00000;
      ex_n = 2;
      case (cls)
         1, 2: begin
            ex[2] = step((cls == 1) ? ST_EX_R : ST_EX_I);
            ex[2].ca = 1; ex[2].alu = alu; ex[2].cr = 1; ex[2].rt = (cls == 2);
            ex[2].ci = (cls == 2); ex[2].imm = imm;
            ex[3] = step(ST_WB); ex[3].ca = 1; ex[3].alu = alu;
            ex[3].strb = (ovf && of_a[2]) ? 5'b00000 : 5'b00100;
            ex[3].cw = 1; ex[3].wrs = (cls == 2) ? 2'b01 : 2'b00; ex[3].wds = 2'b00;
            ex_n = 4;
         end
         3, 4: begin
            ex[2] = step(ST_EX_MA); ex[2].ca = 1; ex[2].alu = 3'b100;
            ex[2].cr = 1; ex[2].rt = 1'b1; ex[2].ci = 1; ex[2].imm = 1'b1;
            if (cls == 3) begin
               ex[3] = step(ST_MEM_RD); ex[3].ca = 1; ex[3].alu = 3'b100;
               ex[3].cw = 1; ex[3].wrs = 2'b01; ex[3].wds = 2'b01;
               ex[4] = step(ST_WB); ex[4].ca = 1; ex[4].alu = 3'b100; ex[4].strb = 5'b00100;
               ex[4].cw = 1; ex[4].wrs = 2'b01; ex[4].wds = 2'b01;
               ex_n = 5;
            end else begin
               ex[3] = step(ST_MEM_WR); ex[3].ca = 1; ex[3].alu = 3'b100; ex[3].strb = 5'b00010;
               ex_n = 4;
            end
         end
         5, 6: begin
            ex[2] = step(ST_BR); ex[2].ca = 1; ex[2].alu = 3'b101; ex[2].cr = 1; ex[2].rt = 1'b0;
            ex[2].cp = 1; ex[2].pcs = 2'b01;
            ex[2].strb = (((cls == 5) ? zf_a[2] : !zf_a[2])) ? 5'b10000 : 5'b00000;
            ex_n = 3;
         end
         7: begin
            ex[2] = step(ST_JMP); ex[2].strb = 5'b10000; ex[2].cp = 1; ex[2].pcs = 2'b10;
            ex_n = 3;
         end
         default: ;
      endcase
   endtask

   task automatic cmp_step(input string nm, input int k);
      chk($sformatf("%s c%0d state", nm, k), 32'(state), 32'(ex[k].st));
      chk($sformatf("%s c%0d strobes", nm, k), 32'(strobes()), 32'(ex[k].strb));
      if (ex[k].ca) chk($sformatf("%s c%0d alu_op", nm, k), 32'(alu_op), 32'(ex[k].alu));
      if (ex[k].cp) chk($sformatf("%s c%0d pc_src", nm, k), 32'(pc_src), 32'(ex[k].pcs));
      if (ex[k].cr) chk($sformatf("%s c%0d rt_imm_s", nm, k), 32'(rt_imm_s), 32'(ex[k].rt));
      if (ex[k].ci) chk($sformatf("%s c%0d imm_s", nm, k), 32'(imm_s), 32'(ex[k].imm));
      if (ex[k].cw) begin
         chk($sformatf("%s c%0d w_r_s", nm, k), 32'(w_r_s), 32'(ex[k].wrs));
         chk($sformatf("%s c%0d wr_data_s", nm, k), 32'(wr_data_s), 32'(ex[k].wds));
      end
   endtask

   // Entered while the DUT sits in IF (already sampled this cycle); returns when it is back in IF.
   task automatic exec(input logic [5:0] eop, input logic [5:0] efn, input int zm, input int om,
                       input string nm, output int len, output logic [2:0] alu2);
      for (int k = 0; k < 8; k++) begin
         zf_a[k] = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
         of_a[k] = (om == 2) ? 1'($urandom_range(0, 1)) : (om == 1);
      end
      build(eop, efn);
      len = 8; alu2 = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 0) begin op = eop; funct = efn; end
         zf = zf_a[k]; of = of_a[k];
         #1;
         if (k > 0 && state == ST_IF) begin len = k; break; end
         if (k == 2) alu2 = alu_op;
         if (k < ex_n) cmp_step(nm, k);
      end
      chk($sformatf("%s length", nm), 32'(len), 32'(ex_n));
   endtask

   task automatic interrupt(input logic [5:0] iop, input logic [5:0] ifn, input int kst,
                            input logic [3:0] est, input string nm);
      op = iop; funct = ifn; zf = 1'b0; of = 1'b0;
      for (int k = 1; k <= kst; k++) begin
         @(negedge clk); #1;
      end
      chk($sformatf("%s reached", nm), 32'(state), 32'(est));
      rst = 1'b1; #1;
      chk($sformatf("%s strobes in rst", nm), 32'(strobes()), 32'd0);
      @(negedge clk); #1;
      chk($sformatf("%s state after rst", nm), 32'(state), 32'(ST_IF));
      chk($sformatf("%s strobes after rst", nm), 32'(strobes()), 32'd0);
      rst = 1'b0; #1;
      chk($sformatf("%s refetch", nm), 32'({state, ir_write}), 32'({ST_IF, 1'b1}));
   endtask

   typedef struct {
      logic [5:0] op; logic [5:0] fn; int zm; int om; int len; bit ca; logic [2:0] alu; string nm;
   } vec_t;

   vec_t       tbl[19];
   logic [5:0] ops[12];
   logic [5:0] fns[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int len; logic [2:0] a2; logic [5:0] rop, rfn;
      tbl[0]  = '{6'b000000, 6'b100000, 0, 0, 4, 1, 3'b100, "add"};
      tbl[1]  = '{6'b000000, 6'b100000, 0, 1, 4, 1, 3'b100, "add_ovf"};
      tbl[2]  = '{6'b001100, 6'b000000, 0, 0, 4, 1, 3'b000, "andi"};
      tbl[3]  = '{6'b100011, 6'b000000, 0, 0, 5, 1, 3'b100, "lw"};
      tbl[4]  = '{6'b101011, 6'b000000, 0, 0, 4, 1, 3'b100, "sw"};
      tbl[5]  = '{6'b000100, 6'b000000, 1, 0, 3, 1, 3'b101, "beq_z1"};
      tbl[6]  = '{6'b000100, 6'b000000, 0, 0, 3, 1, 3'b101, "beq_z0"};
      tbl[7]  = '{6'b000101, 6'b000000, 0, 0, 3, 1, 3'b101, "bne_z0"};
      tbl[8]  = '{6'b000010, 6'b000000, 0, 0, 3, 0, 3'b000, "j"};
      tbl[9]  = '{6'b111111, 6'b000000, 0, 0, 2, 0, 3'b000, "illegal_op"};
      tbl[10] = '{6'b000000, 6'b100010, 0, 1, 4, 1, 3'b101, "sub_ovf"};
      tbl[11] = '{6'b000000, 6'b101011, 0, 1, 4, 1, 3'b110, "sltu_of_ignored"};
      tbl[12] = '{6'b000000, 6'b000100, 0, 0, 4, 1, 3'b111, "sll"};
      tbl[13] = '{6'b000000, 6'b100111, 0, 0, 4, 1, 3'b011, "xnor"};
      tbl[14] = '{6'b001101, 6'b000000, 0, 0, 4, 1, 3'b001, "ori"};
      tbl[15] = '{6'b001110, 6'b000000, 0, 0, 4, 1, 3'b010, "xori"};
      tbl[16] = '{6'b001011, 6'b000000, 0, 0, 4, 1, 3'b110, "sltiu"};
      tbl[17] = '{6'b001000, 6'b000000, 0, 1, 4, 1, 3'b100, "addi_ovf"};
      tbl[18] = '{6'b000000, 6'b111111, 0, 0, 2, 0, 3'b000, "illegal_funct"};
      ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001011,
              6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000000};
      fns = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
              6'b100000, 6'b100010, 6'b101011, 6'b000100};

      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("reset c%0d state", c), 32'(state), 32'(ST_IF));
         chk($sformatf("reset c%0d strobes", c), 32'(strobes()), 32'd0);
         chk($sformatf("reset c%0d alu/pc_src", c), 32'({alu_op, pc_src}), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0; #1;
      chk("first fetch ir_write", 32'(ir_write), 32'd1);

      for (int i = 0; i < 19; i++) begin
         exec(tbl[i].op, tbl[i].fn, tbl[i].zm, tbl[i].om, tbl[i].nm, len, a2);
         chk($sformatf("%s table length", tbl[i].nm), 32'(len), 32'(tbl[i].len));
         if (tbl[i].ca) chk($sformatf("%s table alu_op", tbl[i].nm), 32'(a2), 32'(tbl[i].alu));
      end

      interrupt(6'b101011, 6'd0, 3, ST_MEM_WR, "rst_in_mem_wr");
      interrupt(6'b100011, 6'd0, 2, ST_EX_MA, "rst_in_ex_ma");
      interrupt(6'b000000, 6'b100000, 3, ST_WB, "rst_in_wb");

      for (int n = 0; n < 150; n++) begin
         rop = ($urandom_range(0, 13) < 12) ? ops[$urandom_range(0, 11)] : 6'($urandom);
         rfn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 7)] : 6'($urandom);
         exec(rop, rfn, 2, 2, $sformatf("rnd%0d op%02h fn%02h", n, rop, rfn), len, a2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
